// File: rtl/upower_pkg.sv
// Shared constants for the uPOWER GPR file: data/register geometry and CR0 field layout.
package upower_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam int CR_LT = 3;
  localparam int CR_GT = 2;
  localparam int CR_EQ = 1;
  localparam int CR_SO = 0;
endpackage

// File: rtl/upower_cr0_xer_update.sv
// Combinational next-state for CR0 and XER SO/OV; the parent owns the flops.
module upower_cr0_xer_update
  import upower_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] wr_data,
  input  logic         cr0_we,
  input  logic         ov_we,
  input  logic         alu_overflow,
  input  logic         so_clr,
  input  logic [3:0]   cr0_q,
  input  logic         xer_so_q,
  input  logic         xer_ov_q,
  output logic [3:0]   cr0_d,
  output logic         xer_so_d,
  output logic         xer_ov_d
);
  logic lt, eq;

  always_comb begin
    lt       = wr_data[W-1];
    eq       = ~|wr_data;
    // set beats clear so an overflow coincident with mtxer is not lost
    xer_so_d = (xer_so_q & ~so_clr) | (ov_we & alu_overflow);
    xer_ov_d = ov_we ? alu_overflow : xer_ov_q;
    cr0_d    = cr0_q;
    if (cr0_we) begin
      cr0_d[CR_LT] = lt;
      cr0_d[CR_GT] = ~lt & ~eq;
      cr0_d[CR_EQ] = eq;
      cr0_d[CR_SO] = xer_so_d;
    end
  end
endmodule

// File: rtl/upower_gpr_file.sv
// uPOWER GPR file: 3 async read ports with write-through bypass, 1 write port,
// and CR0/XER status registers folded from the ALU write-back.
module upower_gpr_file
  import upower_pkg::*;
#(
  parameter int XW = XLEN,
  parameter int NR = NREG,
  parameter int AD = AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AD-1:0] ra_addr,
  input  logic          ra_zero,
  input  logic [AD-1:0] rb_addr,
  input  logic [AD-1:0] rs_addr,
  output logic [XW-1:0] ra_data,
  output logic [XW-1:0] rb_data,
  output logic [XW-1:0] rs_data,
  input  logic          wr_en,
  input  logic [AD-1:0] wr_addr,
  input  logic [XW-1:0] wr_data,
  input  logic          cr0_we,
  input  logic          ov_we,
  input  logic          alu_overflow,
  input  logic          so_clr,
  output logic [3:0]    cr0,
  output logic          xer_so,
  output logic          xer_ov
);
  logic [NR-1:0][XW-1:0] gpr_q, gpr_d;
  logic [3:0]            cr0_q, cr0_d;
  logic                  xer_so_q, xer_so_d;
  logic                  xer_ov_q, xer_ov_d;

  always_comb begin
    gpr_d = gpr_q;
    if (wr_en) gpr_d[wr_addr] = wr_data;
  end

  upower_cr0_xer_update #(.W(XW)) u_upd (
    .wr_data      (wr_data),
    .cr0_we       (cr0_we),
    .ov_we        (ov_we),
    .alu_overflow (alu_overflow),
    .so_clr       (so_clr),
    .cr0_q        (cr0_q),
    .xer_so_q     (xer_so_q),
    .xer_ov_q     (xer_ov_q),
    .cr0_d        (cr0_d),
    .xer_so_d     (xer_so_d),
    .xer_ov_d     (xer_ov_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_q    <= '0;
      cr0_q    <= '0;
      xer_so_q <= 1'b0;
      xer_ov_q <= 1'b0;
    end else begin
      gpr_q    <= gpr_d;
      cr0_q    <= cr0_d;
      xer_so_q <= xer_so_d;
      xer_ov_q <= xer_ov_d;
    end
  end

  // Bypass lets a dependent op issued in the write-back cycle see the new value;
  // ra_zero overrides everything for the RA=0 literal form.
  always_comb begin
    ra_data = gpr_q[ra_addr];
    rb_data = gpr_q[rb_addr];
    rs_data = gpr_q[rs_addr];
    if (wr_en && wr_addr == ra_addr) ra_data = wr_data;
    if (wr_en && wr_addr == rb_addr) rb_data = wr_data;
    if (wr_en && wr_addr == rs_addr) rs_data = wr_data;
    if (ra_zero) ra_data = '0;
  end

  assign cr0    = cr0_q;
  assign xer_so = xer_so_q;
  assign xer_ov = xer_ov_q;
endmodule

// File: tb/tb_upower_gpr_file.sv
// Directed bench for upower_gpr_file: reset, bypass, CR0, XER sticky/clear, full sweep.
module tb_upower_gpr_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra_addr, rb_addr, rs_addr, wr_addr;
  logic        ra_zero;
  logic [63:0] ra_data, rb_data, rs_data, wr_data;
  logic        wr_en, cr0_we, ov_we, alu_overflow, so_clr;
  logic [3:0]  cr0;
  logic        xer_so, xer_ov;

  int vectors = 0;
  int miscompares = 0;

  upower_gpr_file dut (
    .clk(clk), .rst(rst),
    .ra_addr(ra_addr), .ra_zero(ra_zero), .rb_addr(rb_addr), .rs_addr(rs_addr),
    .ra_data(ra_data), .rb_data(rb_data), .rs_data(rs_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cr0_we(cr0_we), .ov_we(ov_we), .alu_overflow(alu_overflow), .so_clr(so_clr),
    .cr0(cr0), .xer_so(xer_so), .xer_ov(xer_ov)
  );

  always #5 clk = ~clk;

  // inputs change on the falling edge; outputs are sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 0; cr0_we = 0; ov_we = 0; alu_overflow = 0; so_clr = 0; ra_zero = 0; rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); rst = 1;
    ra_addr = 0; rb_addr = 0; rs_addr = 0; wr_addr = 0; wr_data = 0;
    tick();
    idle();
    wr_en = 1; wr_addr = 5; wr_data = 64'hDEAD_BEEF_0000_0001;
    cr0_we = 1; ov_we = 1; alu_overflow = 1;
    tick();
    idle();
    wr_en = 1; wr_addr = 7; wr_data = 64'd1;
    tick();
    idle();
    ra_addr = 5; rb_addr = 7; #1;
    vectors++;
    if (ra_data !== 64'hDEAD_BEEF_0000_0001 || rb_data !== 64'd1 || cr0 !== 4'b1001 || xer_so !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset ra=%h rb=%h cr0=%b so=%b want dead_beef_0000_0001/1/1001/1", ra_data, rb_data, cr0, xer_so);
    end
    rst = 1; wr_en = 1; wr_addr = 9; wr_data = 64'h55;
    cr0_we = 1; ov_we = 1; alu_overflow = 1;
    tick();
    idle();
    ra_addr = 5; rb_addr = 7; rs_addr = 9; #1;
    vectors++;
    if (ra_data !== 0 || rb_data !== 0 || rs_data !== 0) begin
      miscompares++;
      $display("FAIL reset_gpr ra=%h rb=%h rs=%h want 0", ra_data, rb_data, rs_data);
    end
    vectors++;
    if (cr0 !== 4'b0000 || xer_so !== 1'b0 || xer_ov !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status cr0=%b so=%b ov=%b want 0000/0/0", cr0, xer_so, xer_ov);
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1; wr_addr = 3; wr_data = 64'h1234;
    ra_addr = 3; rb_addr = 3; rs_addr = 3; #1;
    vectors++;
    if (ra_data !== 64'h1234 || rb_data !== 64'h1234 || rs_data !== 64'h1234) begin
      miscompares++;
      $display("FAIL bypass_n ra=%h rb=%h rs=%h want 1234", ra_data, rb_data, rs_data);
    end
    ra_zero = 1; #1;
    vectors++;
    if (ra_data !== 64'h0 || rb_data !== 64'h1234) begin
      miscompares++;
      $display("FAIL bypass_ra_zero ra=%h rb=%h want 0/1234", ra_data, rb_data);
    end
    tick();
    idle(); #1;
    vectors++;
    if (ra_data !== 64'h1234 || rb_data !== 64'h1234 || rs_data !== 64'h1234) begin
      miscompares++;
      $display("FAIL bypass_n1 ra=%h rb=%h rs=%h want 1234", ra_data, rb_data, rs_data);
    end
  endtask

  task automatic test_cr0();
    logic [63:0] vals [3];
    logic [3:0]  exp  [3];
    vals[0] = 64'h8000_0000_0000_0000; exp[0] = 4'b1000;
    vals[1] = 64'h0000_0001_0000_0000; exp[1] = 4'b0100;
    vals[2] = 64'h0;                   exp[2] = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      idle();
      cr0_we = 1; wr_data = vals[i];
      tick();
      idle(); #1;
      vectors++;
      if (cr0 !== exp[i]) begin
        miscompares++;
        $display("FAIL cr0_%0d data=%h cr0=%b want %b", i, vals[i], cr0, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    idle();
    ov_we = 1; alu_overflow = 1;
    tick();
    idle(); #1;
    vectors++;
    if (xer_ov !== 1'b1 || xer_so !== 1'b1) begin
      miscompares++;
      $display("FAIL ov_set ov=%b so=%b want 1/1", xer_ov, xer_so);
    end
    ov_we = 1; alu_overflow = 0; cr0_we = 1; wr_data = 64'd5;
    tick();
    idle(); #1;
    vectors++;
    if (xer_ov !== 1'b0 || xer_so !== 1'b1) begin
      miscompares++;
      $display("FAIL ov_sticky ov=%b so=%b want 0/1", xer_ov, xer_so);
    end
    vectors++;
    if (cr0 !== 4'b0101) begin
      miscompares++;
      $display("FAIL ov_cr0 cr0=%b want 0101", cr0);
    end
  endtask

  task automatic test_clr_set();
    idle();
    so_clr = 1; ov_we = 1; alu_overflow = 1;
    tick();
    idle(); #1;
    vectors++;
    if (xer_so !== 1'b1 || xer_ov !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_set so=%b ov=%b want 1/1", xer_so, xer_ov);
    end
    so_clr = 1; cr0_we = 1; wr_data = 64'd5;
    tick();
    idle(); #1;
    vectors++;
    if (xer_so !== 1'b0 || xer_ov !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_only so=%b ov=%b want 0/1", xer_so, xer_ov);
    end
    vectors++;
    if (cr0 !== 4'b0100) begin
      miscompares++;
      $display("FAIL clr_cr0 cr0=%b want 0100", cr0);
    end
  endtask

  task automatic test_sweep();
    logic [63:0] v;
    for (int i = 0; i < 32; i++) begin
      idle();
      wr_en = 1; wr_addr = 5'(i); wr_data = 64'(i) * 64'h0101_0101_0101_0101;
      tick();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      v = 64'(i) * 64'h0101_0101_0101_0101;
      ra_addr = 5'(i); rb_addr = 5'(31 - i); rs_addr = 5'(i); #1;
      vectors++;
      if (ra_data !== v) begin
        miscompares++;
        $display("FAIL sweep_ra r%0d got %h want %h", i, ra_data, v);
      end
      vectors++;
      if (rb_data !== 64'(31 - i) * 64'h0101_0101_0101_0101) begin
        miscompares++;
        $display("FAIL sweep_rb r%0d got %h want %h", 31 - i, rb_data, 64'(31 - i) * 64'h0101_0101_0101_0101);
      end
      vectors++;
      if (rs_data !== v) begin
        miscompares++;
        $display("FAIL sweep_rs r%0d got %h want %h", i, rs_data, v);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_cr0();
    test_overflow();
    test_clr_set();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/upower_gpr_file.md
Name: upower_gpr_file

Overview:
- uPOWER general-purpose register file with CR0/XER status tracking.
- Sits directly upstream of the 64-bit ALU in the execute path:
  - supplies the RA, RB and RS operands;
  - writes back the ALU Result;
  - folds the ALU Overflow flag and the result sign/zero into CR0 and the XER SO/OV bits.
- Synchronous write, asynchronous read with same-cycle write-through bypass, so a back-to-back dependent ALU op sees the fresh value.

Parameters:
- XLEN, 64, data width; must match the ALU width.
- NREG, 32, number of GPRs.
- AW, 5, register address width (log2 NREG).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ra_addr  in  AW  read port A address.
- ra_zero  in  1  force ra_data to 0 (RA=0 literal form, e.g. addi/ld).
- rb_addr  in  AW  read port B address.
- rs_addr  in  AW  read port S address (store data / logical source).
- ra_data  out  XLEN  operand A to the ALU.
- rb_data  out  XLEN  operand B to the ALU.
- rs_data  out  XLEN  store/source data.
- wr_en  in  1  GPR write enable.
- wr_addr  in  AW  GPR write address.
- wr_data  in  XLEN  write-back data (ALU Result or load data).
- cr0_we  in  1  record-form update of CR0 from wr_data (Rc=1).
- ov_we  in  1  update XER OV/SO from alu_overflow (OE=1).
- alu_overflow  in  1  ALU Overflow flag for the current write-back.
- so_clr  in  1  clear XER SO (mtxer-style).
- cr0  out  4  {LT,GT,EQ,SO}, bit 3 = LT.
- xer_so  out  1  summary overflow, sticky.
- xer_ov  out  1  overflow of the last OE=1 operation.

Behaviour:
- Reset:
  - rst sampled at the rising edge clears all NREG GPRs, cr0, xer_so and xer_ov to 0.
  - rst overrides wr_en, cr0_we, ov_we and so_clr in the same cycle.
  - Mid-operation reset discards the pending write.
- Write:
  - At the rising edge, if wr_en, GPR[wr_addr] <= wr_data.
  - GPR0 is an ordinary writable register; zero-forcing is only via ra_zero.
- Read:
  - Combinational, zero cycle latency.
  - Each port returns wr_data when wr_en && wr_addr == port address (bypass); otherwise it returns the stored value.
  - ra_zero has highest priority: ra_data = 0 regardless of bypass.
  - All three ports may address the same register; each resolves independently.
- XER (edge-updated, priority rst > set > clr):
  - ov_we: xer_ov <= alu_overflow; SO set term = alu_overflow.
  - xer_so <= (xer_so & ~so_clr) | (ov_we & alu_overflow). A set in the same cycle as so_clr wins.
  - ov_we=0: xer_ov holds.
- CR0 (edge-updated when cr0_we; holds otherwise):
  - LT = wr_data[XLEN-1].
  - EQ = (wr_data == 0).
  - GT = ~LT & ~EQ.
  - SO = next-state xer_so, i.e. includes this cycle's overflow and clear.
  - CR0 is computed from wr_data even when wr_en=0 (compare-style records).
- Latency:
  - Written value is visible on reads in the write cycle via bypass, and from storage afterwards.
  - cr0 and xer_* reflect a write-back one cycle after its edge.
- Width:
  - No arithmetic on data.
  - The zero test is a full XLEN-wide reduction; all 64 bits must participate.

Decomposition:
- Shared package upower_pkg holds:
  - XLEN, NREG and AW constants;
  - CR0 bit-index constants (CR_LT=3, CR_GT=2, CR_EQ=1, CR_SO=0).
- Sub-module upower_cr0_xer_update: purely combinational next-state for cr0/xer_so/xer_ov from wr_data, cr0_we, ov_we, alu_overflow, so_clr and current state. The parent holds the flops and the GPR array.

Test Plan:
- Reset:
  - Write r5=0xDEAD_BEEF_0000_0001 and r7=1.
  - Assert rst for 1 cycle together with wr_en (r9=0x55).
  - Required: all reads 0; cr0=0; xer_so=0; xer_ov=0; r9=0.
- Bypass:
  - Cycle N: wr_en, wr_addr=3, wr_data=0x1234, with ra_addr=rb_addr=rs_addr=3.
  - Required: all three ports read 0x1234 in cycle N and again in N+1 with wr_en=0.
  - ra_zero=1 in the same cycle: ra_data=0.
- CR0 sign/zero:
  - cr0_we with wr_data=0x8000_0000_0000_0000 -> cr0=4'b1000.
  - wr_data=0x0000_0001_0000_0000 -> cr0=4'b0100 (upper-half bit must clear EQ).
  - wr_data=0 -> cr0=4'b0010.
- Overflow sticky:
  - ov_we with alu_overflow=1 -> xer_ov=1, xer_so=1.
  - Next op ov_we with alu_overflow=0 -> xer_ov=0, xer_so=1.
  - cr0_we with wr_data=5 in that second op -> cr0=4'b0101.
- Simultaneous clear/set:
  - so_clr=1, ov_we=1, alu_overflow=1 -> xer_so=1.
  - so_clr=1, ov_we=0 -> xer_so=0.
  - cr0_we in the same cycle as the clear -> cr0[0]=0.
- Full sweep:
  - Write r0..r31 with value i*0x0101_0101_0101_0101.
  - Read each on all ports -> exact match; no aliasing across addresses.
